main_control_fsm: RTL
=====================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock for all state.
REQ-002 SHALL have port: reset in 1, synchronous, active-high.
REQ-003 SHALL have port: op in 6, opcode field of the instruction register.
REQ-004 SHALL have port: jr in 1, jump-register flag from the ALU control stage (valid when op=000000).
REQ-005 SHALL have port: mem_ready in 1, memory access complete this cycle.
REQ-006 SHALL have outputs: ALUop out 2, ALUSrcA out 1, ALUSrcB out 2, PCSrc out 2, IorD out 1, MemRead out 1, MemWrite out 1, IRWrite out 1, PCWrite out 1, Branch out 1, RegDst out 1, MemtoReg out 1, RegWrite out 1.
REQ-007 SHALL have outputs: instr_done out 1, one-cycle retire pulse; illegal_op out 1, one-cycle pulse; instr_count out 32, retired-instruction count.

Function
REQ-008 SHALL implement a multi-cycle Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, JRPC, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-009 FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSrc=00; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-010 DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target); next by op: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP; any other -> FETCH with illegal_op=1 for that cycle.
REQ-011 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00; op=100011 -> MEMRD, else -> MEMWR.
REQ-012 MEMRD: IorD=1, MemRead=1; hold until mem_ready=1, then -> MEMWB.
REQ-013 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-014 MEMWR: IorD=1, MemWrite=1; hold until mem_ready=1, then -> FETCH.
REQ-015 EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10; jr=1 -> JRPC, else -> ALUWB.
REQ-016 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-017 JRPC: PCSrc=11, PCWrite=1, RegWrite=0; -> FETCH.
REQ-018 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSrc=01, Branch=1; -> FETCH.
REQ-019 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00; -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-020 JUMP: PCSrc=10, PCWrite=1; -> FETCH.
REQ-021 Every output not listed for a state SHALL be 0 in that state.
REQ-022 instr_done SHALL pulse for exactly one cycle in the last cycle of each instruction (MEMWB, MEMWR with mem_ready=1, ALUWB, JRPC, BRANCH, ADDIWB, JUMP); illegal opcodes SHALL NOT pulse it.
REQ-023 instr_count SHALL increment by 1 on each cycle with instr_done=1, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-024 On a clock edge with reset=1 the FSM SHALL enter FETCH and instr_count SHALL become 0, regardless of current state or mem_ready.
REQ-025 While reset=1, all write enables (IRWrite, PCWrite, MemWrite, RegWrite), MemRead, instr_done and illegal_op SHALL be forced to 0.
REQ-026 Reset asserted mid-instruction (e.g. in MEMRD stall) SHALL abandon the instruction without a retire pulse.

Structure
REQ-027 State encoding, opcode constants and ALUop/PCSrc/ALUSrcB encodings SHALL reside in a shared package used by the datapath and ALU control.
REQ-028 The retire counter MAY be a separate sub-module retire_counter; the FSM itself SHALL be a single module.

Verification
REQ-029 Reset, then op=000000, jr=0, mem_ready=1 -> FETCH, DECODE, EXEC (ALUop=10), ALUWB (RegWrite=1, RegDst=1); instr_count=1.
REQ-030 op=100011 with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles total, MemWrite=0, then MEMWB with MemtoReg=1; instr_done pulses once.
REQ-031 op=000000, jr=1 -> EXEC then JRPC with PCSrc=11, PCWrite=1, RegWrite=0 for the whole instruction.
REQ-032 op=111111 -> DECODE asserts illegal_op=1 for one cycle, next state FETCH, instr_count unchanged.
REQ-033 reset=1 during MEMWR stall -> next state FETCH, MemWrite=0, instr_count=0.
REQ-034 instr_count preset to 0xFFFFFFFF via 2^32-1 retirements (or forced) then op=000010 -> JUMP, PCSrc=10, instr_count=0.

Source files
------------

// File: rtl/main_control_fsm_pkg.sv
// ============================================================================
// main_control_fsm_pkg
// Shared state, opcode and control-field encodings for the multi-cycle core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package main_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_JRPC   = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam int unsigned C_COUNT_W = 32;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  localparam logic [1:0] C_ALUOP_ADD  = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB  = 2'b01;
  localparam logic [1:0] C_ALUOP_FUNC = 2'b10;

  localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] C_PCSRC_JR     = 2'b11;

  localparam logic [1:0] C_SRCB_REG   = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR  = 2'b01;
  localparam logic [1:0] C_SRCB_IMM   = 2'b10;
  localparam logic [1:0] C_SRCB_IMMSH = 2'b11;

endpackage

`default_nettype wire

// File: rtl/main_control_fsm_retire_counter.sv
// ============================================================================
// retire_counter
// Free-running count of retired instructions, wraps at full scale.
// Revision: 1.0
// ============================================================================
`default_nettype none

module retire_counter
  import main_control_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  output logic [C_COUNT_W-1:0] o_count
);

  logic [C_COUNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/main_control_fsm.sv
// ============================================================================
// main_control_fsm
// Multi-cycle Moore control FSM with retire pulse and retired-instruction count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic        jr,
  input  logic        mem_ready,
  output logic [1:0]  ALUop,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Branch,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  state_t r_state;
  state_t w_next;
  logic   w_done;
  logic   w_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    ALUop     = C_ALUOP_ADD;
    ALUSrcA   = 1'b0;
    ALUSrcB   = C_SRCB_REG;
    PCSrc     = C_PCSRC_ALU;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    w_done    = 1'b0;
    w_illegal = 1'b0;

    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = C_SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = C_SRCB_IMMSH;
        case (op)
          C_OP_LW, C_OP_SW: w_next = S_MEMADR;
          C_OP_RTYPE:       w_next = S_EXEC;
          C_OP_BEQ:         w_next = S_BRANCH;
          C_OP_ADDI:        w_next = S_ADDIEX;
          C_OP_J:           w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = C_SRCB_IMM;
        w_next  = (op == C_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          w_done = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = C_ALUOP_FUNC;
        w_next  = jr ? S_JRPC : S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_JRPC: begin
        PCSrc   = C_PCSRC_JR;
        PCWrite = 1'b1;
        w_done  = 1'b1;
        w_next  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUop   = C_ALUOP_SUB;
        PCSrc   = C_PCSRC_ALUOUT;
        Branch  = 1'b1;
        w_done  = 1'b1;
        w_next  = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = C_SRCB_IMM;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = C_PCSRC_JUMP;
        PCWrite = 1'b1;
        w_done  = 1'b1;
        w_next  = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase

    // Reset suppresses every side effect so an abandoned instruction never retires.
    if (reset) begin
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      w_done    = 1'b0;
      w_illegal = 1'b0;
    end

    instr_done = w_done;
    illegal_op = w_illegal;
  end

  retire_counter u_retire (
    .clk     (clk),
    .rst     (reset),
    .i_inc   (w_done),
    .o_count (instr_count)
  );

endmodule

`default_nettype wire
